// File: rtl/up_tpl_pn_mon_pkg.sv
// Shared register map, version and bit-field indices for the per-channel
// PN error monitor on the up_* register bus.
package up_tpl_pn_mon_pkg;

    localparam logic [31:0] VERSION = 32'h0001_0000;

    localparam logic [7:0] OFF_VERSION    = 8'h00;
    localparam logic [7:0] OFF_CTRL       = 8'h01;
    localparam logic [7:0] OFF_OOS_STICKY = 8'h02;
    localparam logic [7:0] OFF_SAT_STICKY = 8'h03;
    localparam logic [7:0] OFF_IRQ_MASK   = 8'h04;
    localparam logic [7:0] OFF_OOS_LIVE   = 8'h05;
    localparam logic [7:0] OFF_COUNT_BASE = 8'h10;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_CLEAR    = 1;
    localparam int CTRL_SNAPSHOT = 2;

    localparam int IRQ_OOS = 0;
    localparam int IRQ_SAT = 1;

endpackage

// File: rtl/up_tpl_pn_err_cnt.sv
// One channel: saturating PN error counter, its snapshot register and a
// one-cycle flag for an increment attempted while already at full scale.
module up_tpl_pn_err_cnt #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   up_clk,
    input  logic                   up_rstn,
    input  logic                   inc_i,
    input  logic                   clear_i,
    input  logic                   snapshot_i,
    output logic [COUNT_WIDTH-1:0] snap_o,
    output logic                   sat_hit_o
);

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] snap_q, snap_d;
    logic                   at_max;

    assign at_max    = &count_q;
    assign sat_hit_o = inc_i & at_max;
    assign snap_o    = snap_q;

    // Snapshot samples the pre-increment value; clear wins over increment,
    // so snapshot+clear together hand the old count over without overlap.
    always_comb begin
        count_d = count_q;
        snap_d  = snap_q;
        if (snapshot_i) begin
            snap_d = count_q;
        end
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !at_max) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // NOTE: snapshot registers are reset too: software may read COUNT before
    // any SNAPSHOT has been issued and must then see 0, not garbage.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            count_q <= '0;
            snap_q  <= '0;
        end else begin
            count_q <= count_d;
            snap_q  <= snap_d;
        end
    end

endmodule

// File: rtl/up_tpl_pn_err_monitor.sv
// Per-channel PN error statistics for the TPL ADC register space: register
// decode, sticky OOS/SAT masks, interrupt and one counter per channel.
module up_tpl_pn_err_monitor
    import up_tpl_pn_mon_pkg::*;
#(
    parameter int          NUM_CHANNELS = 4,
    parameter int          COUNT_WIDTH  = 16,
    parameter logic [1:0]  COMMON_ID    = 2'h2
) (
    input  logic                    up_clk,
    input  logic                    up_rstn,
    input  logic [NUM_CHANNELS-1:0] pn_err,
    input  logic [NUM_CHANNELS-1:0] pn_oos,
    input  logic                    up_wreq,
    input  logic [9:0]              up_waddr,
    input  logic [31:0]             up_wdata,
    output logic                    up_wack,
    input  logic                    up_rreq,
    input  logic [9:0]              up_raddr,
    output logic [31:0]             up_rdata,
    output logic                    up_rack,
    output logic                    irq
);

    logic       wr_sel, rd_sel;
    logic [7:0] woff, roff;

    assign wr_sel = up_wreq & (up_waddr[9:8] == COMMON_ID);
    assign rd_sel = up_rreq & (up_raddr[9:8] == COMMON_ID);
    assign woff   = up_waddr[7:0];
    assign roff   = up_raddr[7:0];

    logic                    enable_q, enable_d;
    logic [1:0]              irq_mask_q, irq_mask_d;
    logic [NUM_CHANNELS-1:0] oos_sticky_q, oos_sticky_d;
    logic [NUM_CHANNELS-1:0] sat_sticky_q, sat_sticky_d;
    logic [NUM_CHANNELS-1:0] oos_w1c, sat_w1c;
    logic                    irq_q, irq_d;
    logic                    wack_q, rack_q;
    logic [31:0]             rdata_q, rdata_d, rd_word;

    logic                                      clear_s, snapshot_s;
    logic [NUM_CHANNELS-1:0]                   inc;
    logic [NUM_CHANNELS-1:0]                   sat_hit;
    logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0]  snap;

    // Write data above the channel mask and CTRL fields is don't-care.
    logic unused_wdata;
    assign unused_wdata = ^up_wdata;

    assign clear_s    = wr_sel & (woff == OFF_CTRL) & up_wdata[CTRL_CLEAR];
    assign snapshot_s = wr_sel & (woff == OFF_CTRL) & up_wdata[CTRL_SNAPSHOT];

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        assign inc[g] = enable_q & pn_err[g] & ~pn_oos[g];

        up_tpl_pn_err_cnt #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_cnt (
            .up_clk     (up_clk),
            .up_rstn    (up_rstn),
            .inc_i      (inc[g]),
            .clear_i    (clear_s),
            .snapshot_i (snapshot_s),
            .snap_o     (snap[g]),
            .sat_hit_o  (sat_hit[g])
        );
    end

    // NOTE: every signal written here gets its default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        enable_d   = enable_q;
        irq_mask_d = irq_mask_q;
        oos_w1c    = '0;
        sat_w1c    = '0;
        if (wr_sel) begin
            case (woff)
                OFF_CTRL:       enable_d   = up_wdata[CTRL_ENABLE];
                OFF_IRQ_MASK:   irq_mask_d = up_wdata[1:0];
                OFF_OOS_STICKY: oos_w1c    = up_wdata[NUM_CHANNELS-1:0];
                OFF_SAT_STICKY: sat_w1c    = up_wdata[NUM_CHANNELS-1:0];
                default:        ;
            endcase
        end
        // A new set event outranks a coincident write-one-to-clear.
        oos_sticky_d = (oos_sticky_q & ~oos_w1c) | pn_oos;
        sat_sticky_d = (sat_sticky_q & ~sat_w1c) | sat_hit;
        irq_d = (irq_mask_q[IRQ_OOS] & (|oos_sticky_q)) |
                (irq_mask_q[IRQ_SAT] & (|sat_sticky_q));
    end

    always_comb begin
        rd_word = '0;
        case (roff)
            OFF_VERSION:    rd_word = VERSION;
            OFF_CTRL:       rd_word = 32'(enable_q);
            OFF_OOS_STICKY: rd_word = 32'(oos_sticky_q);
            OFF_SAT_STICKY: rd_word = 32'(sat_sticky_q);
            OFF_IRQ_MASK:   rd_word = 32'(irq_mask_q);
            OFF_OOS_LIVE:   rd_word = 32'(pn_oos);
            default: begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    if (roff == OFF_COUNT_BASE + 8'(c)) begin
                        rd_word = 32'(snap[c]);
                    end
                end
            end
        endcase
        rdata_d = rd_sel ? rd_word : '0;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            enable_q     <= 1'b0;
            irq_mask_q   <= '0;
            oos_sticky_q <= '0;
            sat_sticky_q <= '0;
            irq_q        <= 1'b0;
            wack_q       <= 1'b0;
            rack_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            enable_q     <= enable_d;
            irq_mask_q   <= irq_mask_d;
            oos_sticky_q <= oos_sticky_d;
            sat_sticky_q <= sat_sticky_d;
            irq_q        <= irq_d;
            wack_q       <= wr_sel;
            rack_q       <= rd_sel;
            rdata_q      <= rdata_d;
        end
    end

    assign up_wack  = wack_q;
    assign up_rack  = rack_q;
    assign up_rdata = rdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_up_tpl_pn_err_monitor.sv
// Bench for up_tpl_pn_err_monitor: a 16-bit and a 4-bit counter instance
// share all inputs and are compared every cycle against a behavioural model.
module tb_up_tpl_pn_err_monitor;

    localparam int          NCH     = 4;
    localparam logic [1:0]  CID     = 2'h2;
    localparam logic [31:0] VERSION = 32'h0001_0000;

    logic             up_clk = 1'b0;
    logic             up_rstn;
    logic [NCH-1:0]   pn_err, pn_oos;
    logic             up_wreq, up_rreq;
    logic [9:0]       up_waddr, up_raddr;
    logic [31:0]      up_wdata;
    logic [1:0]       wack, rack, irq;
    logic [31:0]      rdata [2];

    int checks = 0;
    int errors = 0;

    always #5 up_clk = ~up_clk;

    up_tpl_pn_err_monitor #(.NUM_CHANNELS(NCH), .COUNT_WIDTH(16), .COMMON_ID(CID)) u_dut16 (
        .up_clk(up_clk), .up_rstn(up_rstn), .pn_err(pn_err), .pn_oos(pn_oos),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(wack[0]),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(rdata[0]), .up_rack(rack[0]),
        .irq(irq[0])
    );

    up_tpl_pn_err_monitor #(.NUM_CHANNELS(NCH), .COUNT_WIDTH(4), .COMMON_ID(CID)) u_dut4 (
        .up_clk(up_clk), .up_rstn(up_rstn), .pn_err(pn_err), .pn_oos(pn_oos),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(wack[1]),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(rdata[1]), .up_rack(rack[1]),
        .irq(irq[1])
    );

    // Behavioural model: index 0 is the 16-bit instance, index 1 the 4-bit one.
    int unsigned     cmax [2];
    int unsigned     m_cnt [2][NCH];
    int unsigned     m_snp [2][NCH];
    logic [NCH-1:0]  m_oos_st;
    logic [NCH-1:0]  m_sat_st [2];
    bit              m_en;
    logic [1:0]      m_mask;
    bit              m_irq [2];
    bit              m_wack, m_rack;
    logic [31:0]     m_rdata [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[k][c] = 0;
                m_snp[k][c] = 0;
            end
            m_sat_st[k] = '0;
            m_irq[k]    = 0;
            m_rdata[k]  = '0;
        end
        m_oos_st = '0;
        m_en     = 0;
        m_mask   = '0;
        m_wack   = 0;
        m_rack   = 0;
    endtask

    function automatic logic [31:0] rd_val(int k, logic [7:0] off);
        int idx;
        idx = int'(off) - 16;
        case (off)
            8'h00:   return VERSION;
            8'h01:   return 32'(m_en);
            8'h02:   return 32'(m_oos_st);
            8'h03:   return 32'(m_sat_st[k]);
            8'h04:   return 32'(m_mask);
            8'h05:   return 32'(pn_oos);
            default: return (idx >= 0 && idx < NCH) ? m_snp[k][idx] : 32'h0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [7:0]     wo, ro;
        bit             sw, sr, clr, snp, inc;
        logic [NCH-1:0] w1o, w1s, sat_set;
        wo = up_waddr[7:0];
        ro = up_raddr[7:0];
        sw = up_wreq && (up_waddr[9:8] == CID);
        sr = up_rreq && (up_raddr[9:8] == CID);
        m_wack = sw;
        m_rack = sr;
        for (int k = 0; k < 2; k++) begin
            m_rdata[k] = sr ? rd_val(k, ro) : 32'h0;
            m_irq[k]   = (m_mask[0] && m_oos_st != 0) || (m_mask[1] && m_sat_st[k] != 0);
        end
        clr = sw && wo == 8'h01 && up_wdata[1];
        snp = sw && wo == 8'h01 && up_wdata[2];
        w1o = (sw && wo == 8'h02) ? up_wdata[NCH-1:0] : '0;
        w1s = (sw && wo == 8'h03) ? up_wdata[NCH-1:0] : '0;
        for (int k = 0; k < 2; k++) begin
            sat_set = '0;
            for (int c = 0; c < NCH; c++) begin
                inc = m_en && pn_err[c] && !pn_oos[c];
                if (snp) m_snp[k][c] = m_cnt[k][c];
                if (inc && m_cnt[k][c] == cmax[k]) sat_set[c] = 1'b1;
                if (clr) m_cnt[k][c] = 0;
                else if (inc && m_cnt[k][c] < cmax[k]) m_cnt[k][c] = m_cnt[k][c] + 1;
            end
            m_sat_st[k] = (m_sat_st[k] & ~w1s) | sat_set;
        end
        m_oos_st = (m_oos_st & ~w1o) | pn_oos;
        if (sw && wo == 8'h01) m_en = up_wdata[0];
        if (sw && wo == 8'h04) m_mask = up_wdata[1:0];
    endtask

    task automatic cycle();
        model_step();
        @(posedge up_clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("wack[%0d]", k),  32'(wack[k]), 32'(m_wack));
            check($sformatf("rack[%0d]", k),  32'(rack[k]), 32'(m_rack));
            check($sformatf("rdata[%0d]", k), rdata[k],     m_rdata[k]);
            check($sformatf("irq[%0d]", k),   32'(irq[k]),  32'(m_irq[k]));
        end
    endtask

    task automatic bus_write(input logic [9:0] addr, input logic [31:0] data);
        up_wreq  = 1'b1;
        up_waddr = addr;
        up_wdata = data;
        cycle();
        up_wreq = 1'b0;
        cycle();
    endtask

    task automatic bus_read(input logic [9:0] addr, output logic [31:0] d0,
                            output logic [31:0] d1, output logic [1:0] rk);
        up_rreq  = 1'b1;
        up_raddr = addr;
        cycle();
        d0 = rdata[0];
        d1 = rdata[1];
        rk = rack;
        up_rreq = 1'b0;
        cycle();
    endtask

    task automatic read_expect(input string name, input logic [9:0] addr,
                               input logic [31:0] e0, input logic [31:0] e1);
        logic [31:0] d0, d1;
        logic [1:0]  rk;
        bus_read(addr, d0, d1, rk);
        check({name, "_cw16"}, d0, e0);
        check({name, "_cw4"},  d1, e1);
    endtask

    function automatic logic [7:0] rand_off();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return 8'($urandom_range(0, 5));
            6, 7:             return 8'($urandom_range(16, 21));
            8:                return 8'($urandom);
            default:          return 8'h3F;
        endcase
    endfunction

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [31:0] d0, d1, wd;
        logic [1:0]  rk;
        logic [7:0]  off;

        cmax[0] = 32'hFFFF;
        cmax[1] = 32'hF;
        up_rstn = 1'b0;
        pn_err = '0; pn_oos = '0;
        up_wreq = 1'b0; up_rreq = 1'b0;
        up_waddr = '0; up_raddr = '0; up_wdata = '0;
        model_reset();

        vecs[0]  = '{0, 10'h200, 32'h0,         VERSION};
        vecs[1]  = '{0, 10'h201, 32'h0,         32'h0};
        vecs[2]  = '{0, 10'h210, 32'h0,         32'h0};
        vecs[3]  = '{0, 10'h202, 32'h0,         32'h0};
        vecs[4]  = '{0, 10'h205, 32'h0,         32'h0};
        vecs[5]  = '{0, 10'h214, 32'h0,         32'h0};
        vecs[6]  = '{0, 10'h23F, 32'h0,         32'h0};
        vecs[7]  = '{1, 10'h204, 32'h3,         32'h0};
        vecs[8]  = '{0, 10'h204, 32'h0,         32'h3};
        vecs[9]  = '{1, 10'h201, 32'h7,         32'h0};
        vecs[10] = '{0, 10'h201, 32'h0,         32'h1};
        vecs[11] = '{1, 10'h204, 32'hFFFF_FFFC, 32'h0};
        vecs[12] = '{1, 10'h200, 32'hFFFF_FFFF, 32'h0};
        vecs[13] = '{0, 10'h200, 32'h0,         VERSION};

        repeat (2) @(posedge up_clk);
        #1 up_rstn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("reset_wack",  32'(wack[k]), 32'h0);
            check("reset_rack",  32'(rack[k]), 32'h0);
            check("reset_irq",   32'(irq[k]),  32'h0);
            check("reset_rdata", rdata[k],     32'h0);
        end

        // Register-map table.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, d0, d1, rk);
                check($sformatf("vec%0d_cw16", i), d0, vecs[i].exp);
                check($sformatf("vec%0d_cw4", i),  d1, vecs[i].exp);
                check($sformatf("vec%0d_rack", i), 32'(rk), 32'h3);
            end
        end
        bus_write(10'h201, 32'h0);

        // Seven errors on channel 2.
        bus_write(10'h201, 32'h1);
        pn_err = 4'b0100;
        repeat (7) cycle();
        pn_err = '0;
        bus_write(10'h201, 32'h5);
        read_expect("ch2_count", 10'h212, 32'd7, 32'd7);
        read_expect("ch1_idle",  10'h211, 32'd0, 32'd0);

        // Saturation on channel 0 of the 4-bit instance.
        bus_write(10'h201, 32'h3);
        pn_err = 4'b0001;
        repeat (20) cycle();
        pn_err = '0;
        bus_write(10'h201, 32'h5);
        read_expect("ch0_sat_count", 10'h210, 32'd20, 32'd15);
        read_expect("sat_sticky",    10'h203, 32'h0,  32'h1);
        bus_write(10'h204, 32'h2);
        check("irq_sat_cw4",  32'(irq[1]), 32'h1);
        check("irq_sat_cw16", 32'(irq[0]), 32'h0);
        up_wreq = 1'b1; up_waddr = 10'h203; up_wdata = 32'h1;
        cycle();
        up_wreq = 1'b0;
        check("irq_w1c_lag", 32'(irq[1]), 32'h1);
        cycle();
        check("irq_w1c_clr", 32'(irq[1]), 32'h0);

        // Atomic read-and-clear with errors held on channel 1.
        bus_write(10'h201, 32'h3);
        pn_err = 4'b0010;
        repeat (50) cycle();
        bus_write(10'h201, 32'h7);
        read_expect("rc_first", 10'h211, 32'd50, 32'd15);
        repeat (7) cycle();
        bus_write(10'h201, 32'h5);
        pn_err = '0;
        read_expect("rc_second", 10'h211, 32'd10, 32'd10);

        // Out-of-sync suppresses counting and sets the sticky bit.
        bus_write(10'h202, 32'hF);
        bus_write(10'h201, 32'h3);
        pn_err = 4'b1000; pn_oos = 4'b1000;
        cycle();
        pn_err = '0; pn_oos = '0;
        read_expect("oos_live_low", 10'h205, 32'h0, 32'h0);
        read_expect("oos_sticky",   10'h202, 32'h8, 32'h8);
        bus_write(10'h201, 32'h5);
        read_expect("ch3_no_count", 10'h213, 32'h0, 32'h0);
        pn_oos = 4'b1000;
        read_expect("oos_live_high", 10'h205, 32'h8, 32'h8);
        up_wreq = 1'b1; up_waddr = 10'h202; up_wdata = 32'h8;
        cycle();
        up_wreq = 1'b0; pn_oos = '0;
        cycle();
        read_expect("oos_set_beats_w1c", 10'h202, 32'h8, 32'h8);
        bus_write(10'h202, 32'h8);
        read_expect("oos_w1c", 10'h202, 32'h0, 32'h0);

        // Unselected block: no acks and no side effects.
        up_wreq = 1'b1; up_waddr = 10'h101; up_wdata = 32'h0;
        up_rreq = 1'b1; up_raddr = 10'h300;
        cycle();
        up_wreq = 1'b0; up_rreq = 1'b0;
        check("unsel_wack", 32'(wack), 32'h0);
        check("unsel_rack", 32'(rack), 32'h0);
        cycle();
        read_expect("unsel_ctrl_kept", 10'h201, 32'h1, 32'h1);
        bus_read(10'h214, d0, d1, rk);
        check("oob_rack", 32'(rk), 32'h3);
        check("oob_data", d0 | d1, 32'h0);

        // Randomised traffic.
        for (int n = 0; n < 4000; n++) begin
            pn_err  = NCH'($urandom);
            pn_oos  = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
            up_wreq = ($urandom_range(0, 5) == 0);
            off = rand_off();
            wd  = $urandom;
            if (off == 8'h01) begin
                wd[0] = ($urandom_range(0, 7) != 0);
                wd[1] = ($urandom_range(0, 15) == 0);
                wd[2] = ($urandom_range(0, 3) == 0);
            end
            up_waddr = {($urandom_range(0, 7) == 0) ? 2'($urandom) : CID, off};
            up_wdata = wd;
            up_rreq  = ($urandom_range(0, 3) == 0);
            up_raddr = {($urandom_range(0, 7) == 0) ? 2'($urandom) : CID, rand_off()};
            cycle();
        end
        pn_err = '0; pn_oos = '0; up_wreq = 1'b0; up_rreq = 1'b0;
        bus_write(10'h201, 32'h1);
        bus_write(10'h204, 32'h3);
        pn_err = 4'b1111; pn_oos = 4'b0100;
        repeat (20) cycle();
        pn_err = '0; pn_oos = '0;

        // Reset asserted while a read is pending.
        up_rreq  = 1'b1;
        up_raddr = 10'h200;
        up_rstn  = 1'b0;
        model_reset();
        @(posedge up_clk);
        #1;
        check("rst_rack",  32'(rack), 32'h0);
        check("rst_rdata", rdata[0] | rdata[1], 32'h0);
        check("rst_irq",   32'(irq), 32'h0);
        up_rreq = 1'b0;
        #2 up_rstn = 1'b1;
        read_expect("rst_ctrl", 10'h201, 32'h0, 32'h0);
        read_expect("rst_oos",  10'h202, 32'h0, 32'h0);
        read_expect("rst_sat",  10'h203, 32'h0, 32'h0);
        read_expect("rst_mask", 10'h204, 32'h0, 32'h0);
        for (int c = 0; c < NCH; c++) begin
            read_expect($sformatf("rst_count%0d", c), 10'h210 + 10'(c), 32'h0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
